// File: rtl/lcd_frame_scheduler_if.sv
// lcd_frame_scheduler_if: byte-writer handshake and pixel-source bus of the frame scheduler
interface lcd_frame_scheduler_if;
  logic [8:0] wr_data;
  logic       wr_en;
  logic       wr_done;
  logic [8:0] pix_x;
  logic [8:0] pix_y;
  logic [7:0] pix_data;
  modport master (output wr_data, wr_en, pix_x, pix_y, input wr_done, pix_data);
  modport slave (input wr_data, wr_en, pix_x, pix_y, output wr_done, pix_data);
endinterface

// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: streams CASET/RASET/RAMWR and one full frame of RGB332 pixels into lcd_write; LCD_FRAME_SCHED_CONTINUOUS_EN repeats frames back-to-back
module lcd_frame_scheduler #(
  parameter int H_RES = 240,
  parameter int V_RES = 160,
  parameter int X_OFS = 0,
  parameter int Y_OFS = 0
) (
  input  logic                         clk_25MHz,
  input  logic                         rst_n,
  input  logic                         i_init_done,
  input  logic                         i_frame_start,
  lcd_frame_scheduler_if.master        bus,
  output logic                         o_frame_busy,
  output logic                         o_frame_done
);
  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, PIXELS, DONE} state_t;
  localparam logic [15:0] XS = 16'(X_OFS);
  localparam logic [15:0] XE = 16'(X_OFS + H_RES - 1);
  localparam logic [15:0] YS = 16'(Y_OFS);
  localparam logic [15:0] YE = 16'(Y_OFS + V_RES - 1);
  localparam logic [8:0]  XL = 9'(H_RES - 1);
  localparam logic [8:0]  YL = 9'(V_RES - 1);
`ifdef LCD_FRAME_SCHED_CONTINUOUS_EN
  localparam state_t DONE_NX = CASET;
  logic w_go;
  assign w_go = i_init_done;
`else
  localparam state_t DONE_NX = IDLE;
  logic w_go;
  assign w_go = i_init_done & i_frame_start;
`endif
  state_t     r_state, w_state_nx;
  logic [2:0] r_idx, w_idx_nx;
  logic [8:0] r_x, r_y, w_x_nx, w_y_nx;
  logic       w_last_param, w_last_x, w_last_y;
  assign w_last_param = r_idx == 3'd4;
  assign w_last_x = r_x == XL;
  assign w_last_y = r_y == YL;
  function automatic logic [8:0] param_byte(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e, input logic [2:0] i);
    return i == 3'd0 ? {1'b0, cmd} : i == 3'd1 ? {1'b1, s[15:8]} : i == 3'd2 ? {1'b1, s[7:0]} :
           i == 3'd3 ? {1'b1, e[15:8]} : {1'b1, e[7:0]};
  endfunction
  // state, byte index and pixel coordinate registers
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
    end
  end
  // advance only on wr_done; losing init_done anywhere but IDLE aborts the frame
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    if (r_state != IDLE && !i_init_done) begin
      w_state_nx = IDLE;
      w_idx_nx   = '0;
      w_x_nx     = '0;
      w_y_nx     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nx = w_go ? CASET : IDLE;
          w_idx_nx   = '0;
        end
        CASET, RASET: if (bus.wr_done) begin
          w_idx_nx   = w_last_param ? 3'd0 : r_idx + 3'd1;
          w_state_nx = !w_last_param ? r_state : r_state == CASET ? RASET : RAMWR;
        end
        RAMWR: if (bus.wr_done) begin
          w_state_nx = PIXELS;
          w_x_nx     = '0;
          w_y_nx     = '0;
        end
        PIXELS: if (bus.wr_done) begin
          w_x_nx     = w_last_x ? 9'd0 : r_x + 9'd1;
          w_y_nx     = !w_last_x ? r_y : w_last_y ? 9'd0 : r_y + 9'd1;
          w_state_nx = w_last_x && w_last_y ? DONE : PIXELS;
        end
        DONE: begin
          w_state_nx = DONE_NX;
          w_idx_nx   = '0;
          w_x_nx     = '0;
          w_y_nx     = '0;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end
  // outputs decoded from state, index and coordinates
  always_comb begin
    bus.wr_en    = r_state inside {CASET, RASET, RAMWR, PIXELS};
    o_frame_done = r_state == DONE;
`ifdef LCD_FRAME_SCHED_CONTINUOUS_EN
    o_frame_busy = r_state != IDLE;
`else
    o_frame_busy = r_state inside {CASET, RASET, RAMWR, PIXELS};
`endif
    bus.wr_data  = r_state == CASET  ? param_byte(8'h2A, XS, XE, r_idx) :
                   r_state == RASET  ? param_byte(8'h2B, YS, YE, r_idx) :
                   r_state == RAMWR  ? 9'h02C :
                   r_state == PIXELS ? {1'b1, bus.pix_data} : 9'h000;
    bus.pix_x    = r_x;
    bus.pix_y    = r_y;
  end
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb_lcd_frame_scheduler: randomized-latency byte-writer model with scoreboard checking of the frame stream
module tb_lcd_frame_scheduler;
  localparam int H = 240, V = 4, XO = 0, YO = 272;
  logic clk_25MHz = 0, rst_n = 0, init_done = 0, frame_start = 0;
  logic frame_busy, frame_done;
  int seed = 0, tests = 0, fails = 0, popped = 0, n_done = 0, lat = 0;
  bit fired_last = 0, exp_done = 0;
  typedef struct {logic [8:0] d; int x; int y;} exp_t;
  exp_t q[$];
  exp_t e;
  lcd_frame_scheduler_if bus();
  lcd_frame_scheduler #(.H_RES(H), .V_RES(V), .X_OFS(XO), .Y_OFS(YO)) dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .i_init_done(init_done), .i_frame_start(frame_start),
    .bus(bus), .o_frame_busy(frame_busy), .o_frame_done(frame_done));
  always #20 clk_25MHz = ~clk_25MHz;
  assign bus.pix_data = seed == 0 ? bus.pix_x[7:0] ^ bus.pix_y[7:0] : 8'(bus.pix_x * 3 + bus.pix_y * seed);
  function automatic logic [7:0] pix_model(input int x, input int y);
    return seed == 0 ? 8'((x % 256) ^ (y % 256)) : 8'((x * 3 + y * seed) % 256);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_25MHz);
  endtask
  task automatic push_cmd(input logic [7:0] cmd, input int s, input int en);
    q.push_back('{{1'b0, cmd}, -1, -1});
    q.push_back('{{1'b1, 8'(s / 256)}, -1, -1});
    q.push_back('{{1'b1, 8'(s % 256)}, -1, -1});
    q.push_back('{{1'b1, 8'(en / 256)}, -1, -1});
    q.push_back('{{1'b1, 8'(en % 256)}, -1, -1});
  endtask
  task automatic push_frame();
    q.delete();
    popped = 0;
    push_cmd(8'h2A, XO, XO + H - 1);
    push_cmd(8'h2B, YO, YO + V - 1);
    q.push_back('{9'h02C, -1, -1});
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) q.push_back('{{1'b1, pix_model(x, y)}, x, y});
  endtask
  task automatic start_frame();
    push_frame();
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("start_busy", frame_busy, 1);
    chk("start_wr_en", bus.wr_en, 1);
    chk("start_first_byte", bus.wr_data, 9'h02A);
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while ((frame_busy || q.size() != 0) && n < 20000) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, n < 20000, 1);
    tick(2);
    chk({nm, "_idle_busy"}, frame_busy, 0);
    chk({nm, "_idle_wr_en"}, bus.wr_en, 0);
    chk({nm, "_idle_pix"}, {bus.pix_x, bus.pix_y}, 0);
  endtask
  // lcd_write model: random byte latency, scoreboard pop and frame_done expectation
  initial begin
    bus.wr_done = 0;
    forever begin
      @(negedge clk_25MHz);
      bus.wr_done = 0;
      exp_done = fired_last;
      fired_last = 0;
      if (exp_done || frame_done) begin
        chk("frame_done", frame_done, exp_done);
        if (exp_done) begin
          n_done++;
          chk("done_wr_en", bus.wr_en, 0);
          chk("done_busy", frame_busy, 0);
        end
      end
      if (!rst_n || !bus.wr_en) lat = 0;
      else if (lat == 0) lat = $urandom_range(1, 5);
      else begin
        lat--;
        if (lat == 0) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got %0h expected none", bus.wr_data);
          end else begin
            e = q.pop_front();
            popped++;
            chk("wr_data", bus.wr_data, e.d);
            if (e.x >= 0) begin
              chk("pix_x", bus.pix_x, e.x);
              chk("pix_y", bus.pix_y, e.y);
              fired_last = q.size() == 0;
            end
          end
          bus.wr_done = 1;
        end
      end
    end
  end
  initial begin
    int n;
    tick(3);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_pix", {bus.pix_x, bus.pix_y}, 0);
    chk("rst_busy", frame_busy, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1;
    tick(2);
    frame_start = 1;
    tick();
    frame_start = 0;
    tick(3);
    chk("no_init_busy", frame_busy, 0);
    chk("no_init_wr_en", bus.wr_en, 0);
    init_done = 1;
    tick(2);
    start_frame();
    repeat (4) begin
      tick($urandom_range(50, 400));
      frame_start = 1;
      tick();
      frame_start = 0;
    end
    wait_idle("frame1");
    chk("frame1_count", n_done, 1);
    seed = 7;
    start_frame();
    wait_idle("frame2");
    chk("frame2_count", n_done, 2);
    seed = 0;
    start_frame();
    n = 0;
    while (popped < 511 && n < 20000) begin
      tick();
      n++;
    end
    chk("abort_reach_timeout", n < 20000, 1);
    init_done = 0;
    tick();
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_busy", frame_busy, 0);
    chk("abort_pix", {bus.pix_x, bus.pix_y}, 0);
    q.delete();
    tick(5);
    chk("abort_count", n_done, 2);
    init_done = 1;
    tick(2);
    start_frame();
    wait_idle("restart");
    chk("restart_count", n_done, 3);
    start_frame();
    n = 0;
    while (!(bus.pix_x == 9'd100 && bus.pix_y == 9'd2) && n < 20000) begin
      tick();
      n++;
    end
    chk("rst_reach_timeout", n < 20000, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_wr_en", bus.wr_en, 0);
    chk("mid_rst_busy", frame_busy, 0);
    chk("mid_rst_pix", {bus.pix_x, bus.pix_y}, 0);
    chk("mid_rst_wr_data", bus.wr_data, 0);
    q.delete();
    tick(2);
    rst_n = 1;
    tick(5);
    chk("post_rst_busy", frame_busy, 0);
    chk("post_rst_wr_en", bus.wr_en, 0);
    start_frame();
    wait_idle("final");
    chk("final_count", n_done, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
